// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier, one triplet per cycle.
// Optional early termination: define BOOTH_EARLY_TERM_EN.

module booth_encoder (
  input  logic [2:0] triplet,
  output logic       inv,
  output logic [1:0] shift
);

  always_comb begin
    inv   = 1'b0;
    shift = 2'b00;
    unique case (triplet)
      3'b000: begin inv = 1'b0; shift = 2'b00; end
      3'b001: begin inv = 1'b0; shift = 2'b01; end
      3'b010: begin inv = 1'b0; shift = 2'b01; end
      3'b011: begin inv = 1'b0; shift = 2'b10; end
      3'b100: begin inv = 1'b1; shift = 2'b10; end
      3'b101: begin inv = 1'b1; shift = 2'b01; end
      3'b110: begin inv = 1'b1; shift = 2'b01; end
      3'b111: begin inv = 1'b0; shift = 2'b00; end
    endcase
  end

endmodule

module booth_seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int N  = WIDTH / 2;
  localparam int CW = $clog2(N);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         r_state;
  logic [PW-1:0]  r_mcand;
  logic [WIDTH:0] r_mplier;
  logic [PW-1:0]  r_acc;
  logic [PW-1:0]  r_product;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;

  logic           w_inv;
  logic [1:0]     w_shift;
  logic [PW-1:0]  w_sel;
  logic [PW-1:0]  w_pp;
  logic [PW-1:0]  w_acc_next;
  logic           w_cnt_last;
  logic           w_last;
  logic           w_accept;

  booth_encoder u_enc (
    .triplet (r_mplier[2:0]),
    .inv     (w_inv),
    .shift   (w_shift)
  );

  always_comb begin
    w_sel = '0;
    case (w_shift)
      2'b01:   w_sel = r_mcand;
      2'b10:   w_sel = r_mcand << 1;
      default: w_sel = '0;
    endcase
  end

  assign w_pp       = w_inv ? (~w_sel + PW'(1)) : w_sel;
  assign w_acc_next = r_acc + w_pp;
  assign w_cnt_last = (r_cnt == CW'(N - 1));

`ifdef BOOTH_EARLY_TERM_EN
  // Bits [W:2] hold the processed triplet's top bit plus the
  // unprocessed bits; uniform means every later triplet is zero.
  logic w_rest_eq;
  assign w_rest_eq = (&r_mplier[WIDTH:2]) |
                     (~|r_mplier[WIDTH:2]);
  assign w_last    = w_cnt_last | w_rest_eq;
`else
  assign w_last    = w_cnt_last;
`endif

  assign w_accept = start &&
                    ((r_state == IDLE) || (r_state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_mcand  <= {{WIDTH{multiplicand[WIDTH-1]}},
                         multiplicand};
            r_mplier <= {multiplier, 1'b0};
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= RUN;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
          end else begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
          end
        end
        RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 2;
          r_mplier <= {{2{r_mplier[WIDTH]}},
                       r_mplier[WIDTH:2]};
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_product <= w_acc_next;
            r_state   <= DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and random checks for booth_seq_mult (WIDTH = 16).
// Expected latency follows BOOTH_EARLY_TERM_EN when defined.

module tb_booth_seq_mult;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int tests;
  int fails;

  booth_seq_mult #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic int runcyc(input logic [15:0] b);
`ifdef BOOTH_EARLY_TERM_EN
    logic same;
    for (int k = 1; k < 8; k++) begin
      same = 1'b1;
      for (int j = 2 * k - 1; j < 16; j++)
        if (b[j] != b[15]) same = 1'b0;
      if (same) return k;
    end
    return 8;
`else
    return (b == b) ? 8 : 8;
`endif
  endfunction

  // Counts edges from the accepting edge; returns with done seen.
  task automatic wait_done(input string nm,
                           input int n0,
                           output int n);
    n = n0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_timeout"}, {63'd0, done}, 64'd1);
  endtask

  task automatic run_op(input string nm,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic [31:0] p);
    int n;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_busy"}, {63'd0, busy}, 64'd1);
    wait_done(nm, 1, n);
    chk({nm, "_lat"}, 64'(n), 64'(1 + runcyc(b)));
    chk({nm, "_prod"}, {32'd0, product}, {32'd0, p});
  endtask

  vec_t vecs [12];

  initial begin
    int n;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] rp;
    tests = 0;
    fails = 0;

    vecs[0]  = '{16'd3,     16'd5,     32'd15};
    vecs[1]  = '{16'h8000,  16'h8000,  32'h40000000};
    vecs[2]  = '{16'h7FFF,  16'h8000,  32'hC0008000};
    vecs[3]  = '{16'd1234,  16'd1,     32'd1234};
    vecs[4]  = '{16'hFFF9,  16'd9,     32'hFFFFFFC1};
    vecs[5]  = '{16'd0,     16'h1234,  32'd0};
    vecs[6]  = '{16'hFFFF,  16'hFFFF,  32'd1};
    vecs[7]  = '{16'h7FFF,  16'h7FFF,  32'h3FFF0001};
    vecs[8]  = '{16'hFFFF,  16'h7FFF,  32'hFFFF8001};
    vecs[9]  = '{16'd2,     16'hFFFD,  32'hFFFFFFFA};
    vecs[10] = '{16'h8000,  16'd1,     32'hFFFF8000};
    vecs[11] = '{16'd100,   16'hFF9C,  32'hFFFFD8F0};

    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    rst_n        = 1'b1;
    #1 rst_n     = 1'b0;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_prod", {32'd0, product}, 64'd0);

    // Start already high when reset releases: first edge accepts.
    #20;
    multiplicand = 16'd3;
    multiplier   = 16'd5;
    start        = 1'b1;
    rst_n        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("first_busy", {63'd0, busy}, 64'd1);
    wait_done("first", 1, n);
    chk("first_lat", 64'(n), 64'(1 + runcyc(16'd5)));
    chk("first_prod", {32'd0, product}, 64'd15);

    @(posedge clk); #1;
    chk("idle_done", {63'd0, done}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_hold", {32'd0, product}, 64'd15);

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i),
             vecs[i].a, vecs[i].b, vecs[i].p);
    @(posedge clk); #1;

    // Start during RUN cycle 3 must be ignored.
    multiplicand = 16'd3;
    multiplier   = 16'h4001;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ign_busy", {63'd0, busy}, 64'd1);
    multiplicand = 16'd100;
    multiplier   = 16'd100;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ign", 4, n);
    chk("ign_lat", 64'(n), 64'(1 + runcyc(16'h4001)));
    chk("ign_prod", {32'd0, product}, 64'd49155);

    // Start in DONE begins a new op right away.
    multiplicand = 16'hFFFE;
    multiplier   = 16'd21;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    chk("b2b_done", {63'd0, done}, 64'd0);
    chk("b2b_hold", {32'd0, product}, 64'd49155);
    wait_done("b2b", 1, n);
    chk("b2b_prod", {32'd0, product}, 64'hFFFFFFD6);

    // Reset during RUN cycle 4.
    multiplicand = 16'd3;
    multiplier   = 16'h4001;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_prod", {32'd0, product}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (done || busy) n++;
    end
    chk("no_done_after_rst", 64'(n), 64'd0);
    run_op("post_rst", 16'hFFF9, 16'd9, 32'hFFFFFFC1);
    @(posedge clk); #1;

    for (int i = 0; i < 3000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i < 4) begin
        ra = (i[0]) ? 16'h8000 : 16'h7FFF;
        rb = (i[1]) ? 16'h8000 : 16'h7FFF;
      end
      rp = 32'($signed(ra) * $signed(rb));
      run_op($sformatf("rnd%0d", i), ra, rb, rp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
